mtimer_irq_src: RTL

- Machine-level interrupt source that feeds the CSR register file's t_intr and e_intr inputs. It is the transmitter side of that interrupt interface.
- Contains a 64-bit prescaled mtime counter, a 64-bit mtimecmp compare register, and a synchronizer/edge latch for one asynchronous external interrupt line.
- Sits on the data-memory bus as a small memory-mapped peripheral. Pending interrupts are held until software or mret clears them.

---
 rtl/mtimer_irq_src.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mtimer_irq_src.sv
// Memory-mapped machine timer (prescaled 64-bit mtime/mtimecmp) and external interrupt latch feeding the CSR file.
// Bus access is single-cycle with no wait states; t_intr_o is registered with 1-cycle latency; e_intr_o follows e_irq_i edges after 3 cycles.
module mtimer_irq_src #(
    parameter int DW      = 32,
    parameter int ADDRW   = 5,
    parameter int PRESC_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sel_i,
    input  logic             we_i,
    input  logic [ADDRW-1:0] addr_i,
    input  logic [DW-1:0]    wdata_i,
    output logic [DW-1:0]    rdata_o,
    input  logic             e_irq_i,
    input  logic             is_mret_i,
    output logic             t_intr_o,
    output logic             e_intr_o
);

    localparam logic [2:0] REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] REG_CTRL        = 3'd4;
    localparam logic [2:0] REG_PRESC       = 3'd5;

    logic [2:0]         reg_idx;
    logic               wr_en;
    logic               rd_en;
    logic               wr_mtime_lo;
    logic               wr_mtime_hi;
    logic               wr_cmp_lo;
    logic               wr_cmp_hi;
    logic               wr_ctrl;
    logic               wr_presc;
    logic               rd_mtime_lo;

    logic [63:0]        mtime_q;
    logic [63:0]        mtimecmp_q;
    logic [31:0]        hi_shadow_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_cnt_q;
    logic               tick;

    logic               ctrl_en_q;
    logic               ctrl_tie_q;
    logic               ctrl_eie_q;

    logic               t_intr_q;
    logic               sync1_q;
    logic               sync2_q;
    logic               sync3_q;
    logic               e_rise;
    logic               e_clr;
    logic               e_pending_q;

    logic               unused_addr_bits;

    assign reg_idx          = addr_i[4:2];
    assign unused_addr_bits = ^addr_i[1:0];

    assign wr_en       = sel_i & we_i;
    assign rd_en       = sel_i & ~we_i;
    assign wr_mtime_lo = wr_en & (reg_idx == REG_MTIME_LO);
    assign wr_mtime_hi = wr_en & (reg_idx == REG_MTIME_HI);
    assign wr_cmp_lo   = wr_en & (reg_idx == REG_MTIMECMP_LO);
    assign wr_cmp_hi   = wr_en & (reg_idx == REG_MTIMECMP_HI);
    assign wr_ctrl     = wr_en & (reg_idx == REG_CTRL);
    assign wr_presc    = wr_en & (reg_idx == REG_PRESC);
    assign rd_mtime_lo = rd_en & (reg_idx == REG_MTIME_LO);

    // Prescaler: a tick fires on the cycle the count matches PRESC.
    assign tick = ctrl_en_q & (presc_cnt_q == presc_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_cnt_q <= '0;
        end else if (wr_presc) begin
            presc_cnt_q <= '0;
        end else if (ctrl_en_q) begin
            presc_cnt_q <= tick ? '0 : presc_cnt_q + 1'b1;
        end
    end

    // A software write to either mtime half wins over the tick in that cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime_q <= '0;
        end else if (wr_mtime_lo) begin
            mtime_q[31:0] <= wdata_i[31:0];
        end else if (wr_mtime_hi) begin
            mtime_q[63:32] <= wdata_i[31:0];
        end else if (tick) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtimecmp_q <= '1;
        end else if (wr_cmp_lo) begin
            mtimecmp_q[31:0] <= wdata_i[31:0];
        end else if (wr_cmp_hi) begin
            mtimecmp_q[63:32] <= wdata_i[31:0];
        end
    end

    // Reading LO freezes HI so software gets a coherent 64-bit value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_shadow_q <= '0;
        end else if (rd_mtime_lo) begin
            hi_shadow_q <= mtime_q[63:32];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_en_q  <= 1'b0;
            ctrl_tie_q <= 1'b0;
            ctrl_eie_q <= 1'b0;
            presc_q    <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en_q  <= wdata_i[0];
                ctrl_tie_q <= wdata_i[1];
                ctrl_eie_q <= wdata_i[2];
            end
            if (wr_presc) begin
                presc_q <= wdata_i[PRESC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            t_intr_q <= 1'b0;
        end else begin
            t_intr_q <= ctrl_tie_q & (mtime_q >= mtimecmp_q);
        end
    end

    // Two flops resynchronise e_irq_i; the third gives the previous value for edge detect.
    assign e_rise = sync2_q & ~sync3_q;
    assign e_clr  = is_mret_i | (wr_ctrl & wdata_i[9]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            e_pending_q <= 1'b0;
        end else begin
            sync1_q <= e_irq_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (e_rise) begin
                e_pending_q <= 1'b1;
            end else if (e_clr) begin
                e_pending_q <= 1'b0;
            end
        end
    end

    assign t_intr_o = t_intr_q;
    assign e_intr_o = e_pending_q & ctrl_eie_q;

    always_comb begin
        rdata_o = '0;
        if (rd_en) begin
            case (reg_idx)
                REG_MTIME_LO:    rdata_o = mtime_q[31:0];
                REG_MTIME_HI:    rdata_o = hi_shadow_q;
                REG_MTIMECMP_LO: rdata_o = mtimecmp_q[31:0];
                REG_MTIMECMP_HI: rdata_o = mtimecmp_q[63:32];
                REG_CTRL: begin
                    rdata_o[0] = ctrl_en_q;
                    rdata_o[1] = ctrl_tie_q;
                    rdata_o[2] = ctrl_eie_q;
                    rdata_o[8] = t_intr_q;
                    rdata_o[9] = e_pending_q;
                end
                REG_PRESC:       rdata_o = {{(DW-PRESC_W){1'b0}}, presc_q};
                default:         rdata_o = '0;
            endcase
        end
    end

endmodule
